round_controller: RTL and testbench

- Sequences one round of the memory game: SHOW writes DISPLAY_CYCLE random values into the shared 16x10 pattern memory and shows them on LEDs, one per game_tick.
- RECALL reads each stored value back and compares it with the player's switch entry.
- Sole master of the pattern memory port. Drives win/lose/score to the display logic.

---
 rtl/memgame_pkg.sv | 27 ++
 rtl/round_controller_if.sv | 13 +
 rtl/round_controller_key_edge_detect.sv | 29 ++
 rtl/round_controller.sv | 197 +++++++++++++++++++
 tb/tb_round_controller.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory game: state encoding, memory geometry
// and seven-segment codes used by the hex display decoder.
package memgame_pkg;

    localparam int ADDR_W            = 4;
    localparam int DATA_W            = 10;
    localparam int DISPLAY_CYCLE_DEF = 10;
    localparam int TIMEOUT_TICKS_DEF = 50;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHOW    = 3'd1,
        WAIT_IN = 3'd2,
        FETCH   = 3'd3,
        CHECK   = 3'd4,
        WIN     = 3'd5,
        LOSE    = 3'd6
    } state_t;

    // Active-low segment codes, bit order gfedcba
    localparam logic [6:0] SEG_G    = 7'b1000010;
    localparam logic [6:0] SEG_O    = 7'b1000000;
    localparam logic [6:0] SEG_I    = 7'b1111001;
    localparam logic [6:0] SEG_N    = 7'b0101011;
    localparam logic [6:0] SEG_NONE = 7'b1111111;

endpackage

// File: rtl/round_controller_if.sv
// Pattern memory port; the round controller is the only master, the 16x10 RAM the slave.
interface round_controller_if;
    import memgame_pkg::*;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
    modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);

endinterface

// File: rtl/round_controller_key_edge_detect.sv
// Two-flop synchroniser for an active-low push button plus a one-clk press pulse
// on the falling edge of the synchronised level.
module key_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic key_n,
    output logic press_p
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Flops clear to 0, so a released key after reset looks like a rising edge: no pulse
    assign press_p = sync3 & ~sync2;

endmodule

// File: rtl/round_controller.sv
// Memory game round sequencer: SHOW stores and displays a random pattern, RECALL checks
// player entries against it. Macro ROUND_TIMEOUT_EN adds a game_tick timeout in WAIT_IN.
//
//  state   | meaning
//  IDLE    | waiting for start press, LEDs dark
//  SHOW    | one random value written and shown per game_tick
//  WAIT_IN | LEDs echo switches, waiting for confirm
//  FETCH   | read latency of the pattern memory
//  CHECK   | compare stored value with the latched guess
//  WIN     | all entries correct, LEDs all on, wait for start
//  LOSE    | wrong entry (or timeout), LEDs dark, wait for start
module round_controller
    import memgame_pkg::*;
#(
    parameter int DISPLAY_CYCLE = DISPLAY_CYCLE_DEF
`ifdef ROUND_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
`endif
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               game_tick,
    input  logic               start_key,
    input  logic               confirm_key,
    input  logic [DATA_W-1:0]  sw,
    input  logic [DATA_W-1:0]  randnum,
    round_controller_if.master mem,
    output logic [DATA_W-1:0]  led,
    output logic [3:0]         score,
    output logic [2:0]         state,
    output logic               win,
    output logic               lose
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DISPLAY_CYCLE - 1);

    state_t            cur_st;
    state_t            nxt_st;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] guess;
    logic              start_p;
    logic              confirm_p;
    logic              last_idx;
    logic              match;
    logic              timeout_hit;

    key_edge_detect u_start_edge (
        .clk     (clk),
        .resetn  (resetn),
        .key_n   (start_key),
        .press_p (start_p)
    );

    key_edge_detect u_confirm_edge (
        .clk     (clk),
        .resetn  (resetn),
        .key_n   (confirm_key),
        .press_p (confirm_p)
    );

    assign last_idx = (idx == LAST_IDX);
    assign match    = (mem.mem_rdata == guess);
    assign state    = cur_st;
    // idx only moves in SHOW and CHECK, so it doubles as the read address during FETCH
    assign mem.mem_addr = idx;

`ifdef ROUND_TIMEOUT_EN
    localparam logic [5:0] TO_LAST = 6'(TIMEOUT_TICKS - 1);

    logic [5:0] tick_cnt;

    // Held at zero outside WAIT_IN, so every entry into WAIT_IN starts a fresh count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
        end else if (cur_st != WAIT_IN) begin
            tick_cnt <= '0;
        end else if (game_tick) begin
            tick_cnt <= tick_cnt + 6'd1;
        end
    end

    assign timeout_hit = (cur_st == WAIT_IN) && game_tick && (tick_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_st <= IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st        = cur_st;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = '0;
        case (cur_st)
            IDLE: begin
                if (start_p) nxt_st = SHOW;
            end
            SHOW: begin
                if (game_tick) begin
                    mem.mem_we    = 1'b1;
                    mem.mem_wdata = randnum;
                    if (last_idx) nxt_st = WAIT_IN;
                end
            end
            WAIT_IN: begin
                // A confirm on the final timeout tick still counts as an entry
                if (confirm_p)        nxt_st = FETCH;
                else if (timeout_hit) nxt_st = LOSE;
            end
            FETCH: begin
                nxt_st = CHECK;
            end
            CHECK: begin
                if (!match)        nxt_st = LOSE;
                else if (last_idx) nxt_st = WIN;
                else               nxt_st = WAIT_IN;
            end
            WIN, LOSE: begin
                if (start_p) nxt_st = SHOW;
            end
            default: nxt_st = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx   <= '0;
            guess <= '0;
            led   <= '0;
            score <= '0;
            win   <= 1'b0;
            lose  <= 1'b0;
        end else begin
            case (cur_st)
                IDLE: begin
                    led <= '0;
                    if (start_p) begin
                        idx   <= '0;
                        score <= '0;
                    end
                end
                SHOW: begin
                    if (game_tick) begin
                        if (last_idx) begin
                            idx <= '0;
                            led <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                            led <= randnum;
                        end
                    end
                end
                WAIT_IN: begin
                    led <= sw;
                    if (confirm_p) begin
                        guess <= sw;
                    end else if (timeout_hit) begin
                        lose <= 1'b1;
                        led  <= '0;
                    end
                end
                CHECK: begin
                    if (match) begin
                        if (score != 4'd15) score <= score + 4'd1;
                        if (last_idx) begin
                            win <= 1'b1;
                            led <= '1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else begin
                        lose <= 1'b1;
                        led  <= '0;
                    end
                end
                WIN, LOSE: begin
                    if (start_p) begin
                        win   <= 1'b0;
                        lose  <= 1'b0;
                        score <= '0;
                        idx   <= '0;
                        led   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with a behavioural 16x10 pattern memory.
module tb_round_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       game_tick = 1'b0;
    logic       start_key = 1'b1;
    logic       confirm_key = 1'b1;
    logic [9:0] sw = '0;
    logic [9:0] randnum = '0;
    logic [9:0] led;
    logic [3:0] score;
    logic [2:0] state;
    logic       win;
    logic       lose;

    int errors = 0;
    int checks = 0;

    round_controller_if mif ();

    round_controller #(
        .DISPLAY_CYCLE (10)
`ifdef ROUND_TIMEOUT_EN
        ,
        .TIMEOUT_TICKS (3)
`endif
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .game_tick   (game_tick),
        .start_key   (start_key),
        .confirm_key (confirm_key),
        .sw          (sw),
        .randnum     (randnum),
        .mem         (mif),
        .led         (led),
        .score       (score),
        .state       (state),
        .win         (win),
        .lose        (lose)
    );

    always #5 clk = ~clk;

    // Pattern memory model with 1-cycle synchronous read, plus a log of every write
    logic [9:0] pmem [16];
    logic [3:0] wr_addr [64];
    logic [9:0] wr_data [64];
    int         wr_total = 0;

    always @(posedge clk) begin
        if (mif.mem_we) begin
            pmem[mif.mem_addr]    <= mif.mem_wdata;
            wr_addr[wr_total % 64] <= mif.mem_addr;
            wr_data[wr_total % 64] <= mif.mem_wdata;
            wr_total              <= wr_total + 1;
        end
        mif.mem_rdata <= pmem[mif.mem_addr];
    end

    typedef struct {
        logic [9:0] sw;
        logic [2:0] st;
        logic [3:0] sc;
        logic [9:0] led;
        logic       w;
        logic       l;
    } vec_t;

    vec_t win_tab [10];
    vec_t lose_tab [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic [3:0] sc,
                              input logic [9:0] l, input logic w, input logic lo);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_score"}, 32'(score), 32'(sc));
        check({tag, "_led"},   32'(led),   32'(l));
        check({tag, "_win"},   32'(win),   32'(w));
        check({tag, "_lose"},  32'(lose),  32'(lo));
    endtask

    task automatic tick();
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    task automatic press(input bit is_start);
        if (is_start) start_key = 1'b0;
        else          confirm_key = 1'b0;
        repeat (4) @(negedge clk);
        start_key   = 1'b1;
        confirm_key = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic show_round();
        for (int k = 1; k <= 10; k++) begin
            randnum = 10'(k);
            tick();
            @(negedge clk);
        end
    endtask

    task automatic apply_tab(input string tag, input vec_t v);
        sw = v.sw;
        press(1'b0);
        check_outs(tag, v.st, v.sc, v.led, v.w, v.l);
    endtask

    int base;

    initial begin
        win_tab[0] = '{10'd1,  3'd2, 4'd1,  10'd1,   1'b0, 1'b0};
        win_tab[1] = '{10'd2,  3'd2, 4'd2,  10'd2,   1'b0, 1'b0};
        win_tab[2] = '{10'd3,  3'd2, 4'd3,  10'd3,   1'b0, 1'b0};
        win_tab[3] = '{10'd4,  3'd2, 4'd4,  10'd4,   1'b0, 1'b0};
        win_tab[4] = '{10'd5,  3'd2, 4'd5,  10'd5,   1'b0, 1'b0};
        win_tab[5] = '{10'd6,  3'd2, 4'd6,  10'd6,   1'b0, 1'b0};
        win_tab[6] = '{10'd7,  3'd2, 4'd7,  10'd7,   1'b0, 1'b0};
        win_tab[7] = '{10'd8,  3'd2, 4'd8,  10'd8,   1'b0, 1'b0};
        win_tab[8] = '{10'd9,  3'd2, 4'd9,  10'd9,   1'b0, 1'b0};
        win_tab[9] = '{10'd10, 3'd5, 4'd10, 10'h3FF, 1'b1, 1'b0};
        lose_tab[0] = '{10'd1, 3'd2, 4'd1, 10'd1, 1'b0, 1'b0};
        lose_tab[1] = '{10'd2, 3'd2, 4'd2, 10'd2, 1'b0, 1'b0};
        lose_tab[2] = '{10'd7, 3'd6, 4'd2, 10'd0, 1'b0, 1'b1};

        // Power-on reset
        repeat (2) @(negedge clk);
        check_outs("rst", 3'd0, 4'd0, 10'd0, 1'b0, 1'b0);
        check("rst_we", 32'(mif.mem_we), 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_state", 32'(state), 32'd0);

        // Start, confirm during SHOW ignored, then reset after four values
        press(1'b1);
        check("start_state", 32'(state), 32'd1);
        press(1'b0);
        check("show_confirm_state", 32'(state), 32'd1);
        check("show_confirm_wr", 32'(wr_total), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            randnum = 10'(k);
            tick();
            @(negedge clk);
        end
        check("show4_led", 32'(led), 32'd4);
        check("show4_wr", 32'(wr_total), 32'd4);
        #2 resetn = 1'b0;
        @(negedge clk);
        check_outs("midrst", 3'd0, 4'd0, 10'd0, 1'b0, 1'b0);
        check("midrst_we", 32'(mif.mem_we), 32'd0);
        check("midrst_addr", 32'(mif.mem_addr), 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Full SHOW of 1..10
        base = wr_total;
        press(1'b1);
        show_round();
        check("show_wr_count", 32'(wr_total - base), 32'd10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("show_addr%0d", k), 32'(wr_addr[base + k]), 32'(k));
            check($sformatf("show_data%0d", k), 32'(wr_data[base + k]), 32'(k + 1));
        end
        check_outs("show_done", 3'd2, 4'd0, 10'd0, 1'b0, 1'b0);

        // Start ignored in WAIT_IN
        base = wr_total;
        press(1'b1);
        check("waitin_start_state", 32'(state), 32'd2);
        check("waitin_start_wr", 32'(wr_total - base), 32'd0);
`ifndef ROUND_TIMEOUT_EN
        repeat (5) begin
            tick();
            @(negedge clk);
        end
        check("waitin_ticks_state", 32'(state), 32'd2);
        check("waitin_ticks_wr", 32'(wr_total - base), 32'd0);
`endif

        // Full correct recall
        for (int i = 0; i < 10; i++) apply_tab($sformatf("win%0d", i), win_tab[i]);

        // New round from WIN, third guess wrong
        press(1'b1);
        check_outs("restart", 3'd1, 4'd0, 10'd0, 1'b0, 1'b0);
        show_round();
        for (int i = 0; i < 3; i++) apply_tab($sformatf("lose%0d", i), lose_tab[i]);
        sw = 10'd3;
        press(1'b0);
        check_outs("lose_confirm", 3'd6, 4'd2, 10'd0, 1'b0, 1'b1);

`ifdef ROUND_TIMEOUT_EN
        // Three ticks without a confirm
        press(1'b1);
        show_round();
        tick();
        tick();
        check("to_2ticks_state", 32'(state), 32'd2);
        tick();
        check_outs("to_lose", 3'd6, 4'd0, 10'd0, 1'b0, 1'b1);

        // Confirm pulse lands on the same clk as the third tick
        press(1'b1);
        show_round();
        tick();
        tick();
        confirm_key = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tick();
        check("to_coincide_state", 32'(state), 32'd3);
        check("to_coincide_lose", 32'(lose), 32'd0);
        confirm_key = 1'b1;
        repeat (4) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
